dsp48a1_mac_sequencer: RTL and testbench

Controller that sequences one DSP48A1 slice as a signed multiply-accumulate engine. It accepts a job of length N, streams N operand pairs into the slice through a valid/ready handshake, and drives OPMODE cycle by cycle. The product pipeline and the P feedback path stay aligned across input bubbles. When the job completes, it captures the 48-bit sum and presents it on a result handshake. The block sits between a requester (a filter or matrix engine) and a DSP48A1 instance. That instance has A1REG=B1REG=MREG=PREG=OPMODEREG=1, CE tied high, and D, C and CARRYIN tied to zero.

---
 rtl/dsp48a1_mac_sequencer.sv | 160 ++++++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer
// Drives one DSP48A1 slice (A1/B1/M/P/OPMODE registered) as a signed MAC.
// A job of N operand pairs is streamed into the slice. Each pair carries a
// slot tag that is delayed to line up with the M register and is then turned
// into OPMODE. Bubbles become HOLD slots (X=0, Z=P), so the running sum
// survives gaps in op_valid. After the last pair, the pipeline is drained and
// P is captured into res_data.
module dsp48a1_mac_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [17:0]      op_a,
  input  logic [17:0]      op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic             busy,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    TAG_HOLD,
    TAG_FIRST,
    TAG_ACC
  } tag_t;

  localparam int TAG_STAGES = MUL_LAT - 1;
  localparam int DRAIN_W    = $clog2(MUL_LAT + 3) + 1;
  // The final term reaches P MUL_LAT+1 edges after its accept. The counter
  // runs down to zero, and P is taken on the edge after that.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MUL_LAT + 2);

  localparam logic [7:0] OPM_FIRST = 8'b0000_0001;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC   = 8'b0000_1001;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD  = 8'b0000_1000;  // X=0, Z=P

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining;
  logic [DRAIN_W-1:0] drain;
  logic               first_pending;
  tag_t               tag_pipe [TAG_STAGES];
  logic               cmd_accept;
  logic               op_accept;
  logic               last_accept;

  assign last_accept = op_accept && (remaining == LEN_W'(1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments, so every register
    // samples pre-edge values no matter what order the statements are in.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    // NOTE: every output gets a default first. An unassigned path would
    // otherwise infer a latch.
    state_d    = state_q;
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    cmd_accept = 1'b0;
    op_accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cmd_accept = 1'b1;
          state_d    = (cmd_len == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_accept = 1'b1;
          if (remaining == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain == '0) state_d = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job bookkeeping: remaining terms, drain countdown and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining     <= '0;
      drain         <= '0;
      res_data      <= '0;
      first_pending <= 1'b0;
    end else begin
      if (cmd_accept) begin
        remaining     <= cmd_len;
        first_pending <= 1'b1;
        if (cmd_len == '0) res_data <= '0;
      end
      if (op_accept) begin
        remaining     <= remaining - LEN_W'(1);
        first_pending <= 1'b0;
      end
      if (last_accept) drain <= DRAIN_LOAD;
      if (state_q == S_DRAIN) begin
        if (drain == '0) res_data <= dsp_p;
        else             drain    <= drain - DRAIN_W'(1);
      end
    end
  end

  // Operand registers plus the slot-tag delay line and the OPMODE register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= OPM_HOLD;
      // NOTE: this small delay line is reset element by element. It must
      // come up as HOLD so that no stray product reaches P.
      for (int i = 0; i < TAG_STAGES; i++) tag_pipe[i] <= TAG_HOLD;
    end else begin
      dsp_a <= op_accept ? op_a : '0;
      dsp_b <= op_accept ? op_b : '0;
      if (!op_accept)         tag_pipe[0] <= TAG_HOLD;
      else if (first_pending) tag_pipe[0] <= TAG_FIRST;
      else                    tag_pipe[0] <= TAG_ACC;
      for (int i = 1; i < TAG_STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
      case (tag_pipe[TAG_STAGES-1])
        TAG_FIRST: dsp_opmode <= OPM_FIRST;
        TAG_ACC:   dsp_opmode <= OPM_ACC;
        default:   dsp_opmode <= OPM_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb_dsp48a1_mac_sequencer
// Directed bench. It contains a behavioural DSP48A1 slice (A1/B1/M/OPMODE/P
// registers) whose P feeds back into the sequencer. Expected sums are
// hand-computed constants.
module tb_dsp48a1_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic        op_valid;
  logic        op_ready;
  logic [17:0] op_a;
  logic [17:0] op_b;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic        busy;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp48a1_mac_sequencer #(.MUL_LAT(2), .LEN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p)
  );

  // Behavioural slice: A1/B1 -> M (signed 18x18) -> P, with the OPMODE register
  // aligned to M. P starts with garbage, so a missing Z=0 on FIRST shows up.
  logic signed [17:0] a1 = '0;
  logic signed [17:0] b1 = '0;
  logic signed [35:0] m_reg = '0;
  logic        [7:0]  opm_reg = 8'h08;
  logic        [47:0] p_reg = 48'h1234_5678_9ABC;
  logic        [47:0] x_mux;
  logic        [47:0] z_mux;

  assign dsp_p = p_reg;
  assign x_mux = (opm_reg[1:0] == 2'b01) ? {{12{m_reg[35]}}, m_reg} : 48'd0;
  assign z_mux = (opm_reg[3:2] == 2'b10) ? p_reg : 48'd0;

  always @(posedge clk) begin
    a1      <= dsp_a;
    b1      <= dsp_b;
    m_reg   <= a1 * b1;
    opm_reg <= dsp_opmode;
    p_reg   <= z_mux + x_mux;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("cmd_ready_timeout", 1'b0, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
    int n = 0;
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!op_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("op_ready_timeout", 1'b0, 1'b1);
    tick();
    op_valid = 1'b0;
  endtask

  // Call right after the last accept. Counts edges until res_valid rises.
  task automatic wait_result(input string tag, input logic [47:0] exp, input int exp_lat);
    int n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    check({tag, "_latency"}, 48'(n), 48'(exp_lat));
    check({tag, "_data"}, res_data, exp);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_cmd_ready_after"}, 48'(cmd_ready), 48'd1);
    check({tag, "_res_valid_after"}, 48'(res_valid), 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int seen;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_res_valid", 48'(res_valid), 48'd0);
    check("rst_op_ready",  48'(op_ready),  48'd0);
    check("rst_cmd_ready", 48'(cmd_ready), 48'd1);
    check("rst_opmode",    48'(dsp_opmode), 48'h08);
    check("rst_busy",      48'(busy),      48'd0);
    rst = 1'b0;
    tick();

    // Back-to-back job: 12 - 10 + 100 = 102
    do_cmd(8'd3);
    check("j1_op_ready", 48'(op_ready), 48'd1);
    check("j1_cmd_ready", 48'(cmd_ready), 48'd0);
    check("j1_busy", 48'(busy), 48'd1);
    send_pair(18'sd3, 18'sd4);
    send_pair(-18'sd2, 18'sd5);
    check("j1_opmode_first", 48'(dsp_opmode), 48'h01);
    send_pair(18'sd10, 18'sd10);
    check("j1_opmode_acc", 48'(dsp_opmode), 48'h09);
    wait_result("j1", 48'd102, 5);
    take_result("j1");

    // Same job with a two-cycle bubble between pairs 1 and 2
    do_cmd(8'd3);
    send_pair(18'sd3, 18'sd4);
    tick();
    check("j2_opmode_first", 48'(dsp_opmode), 48'h01);
    tick();
    check("j2_opmode_hold0", 48'(dsp_opmode), 48'h08);
    send_pair(-18'sd2, 18'sd5);
    check("j2_opmode_hold1", 48'(dsp_opmode), 48'h08);
    send_pair(18'sd10, 18'sd10);
    check("j2_opmode_acc", 48'(dsp_opmode), 48'h09);
    wait_result("j2", 48'd102, 5);
    take_result("j2");

    // Most-negative squared, then an immediate job that must ignore stale P
    do_cmd(8'd1);
    send_pair(18'h20000, 18'h20000);
    wait_result("j3", 48'd17179869184, 5);
    take_result("j3");
    do_cmd(8'd1);
    send_pair(18'sd7, -18'sd3);
    wait_result("j4", 48'hFFFF_FFFF_FFEB, 5);
    take_result("j4");

    // Result held under back-pressure: 100*-200 + 5*6 = -19970
    do_cmd(8'd2);
    send_pair(18'sd100, -18'sd200);
    send_pair(18'sd5, 18'sd6);
    wait_result("j5", 48'hFFFF_FFFF_B1FE, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("j5_hold_valid", 48'(res_valid), 48'd1);
      check("j5_hold_data", res_data, 48'hFFFF_FFFF_B1FE);
      check("j5_hold_cmd_ready", 48'(cmd_ready), 48'd0);
    end
    take_result("j5");

    // Zero-length job completes the cycle after acceptance with 0
    do_cmd(8'd0);
    check("j6_res_valid", 48'(res_valid), 48'd1);
    check("j6_res_data", res_data, 48'd0);
    check("j6_op_ready", 48'(op_ready), 48'd0);
    take_result("j6");

    // Reset in the middle of a job discards it
    do_cmd(8'd4);
    send_pair(18'sd1000, 18'sd1000);
    send_pair(18'sd2000, 18'sd2000);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 48'(busy), 48'd0);
    check("mid_rst_op_ready", 48'(op_ready), 48'd0);
    check("mid_rst_cmd_ready", 48'(cmd_ready), 48'd1);
    check("mid_rst_opmode", 48'(dsp_opmode), 48'h08);
    check("mid_rst_dsp_a", 48'(dsp_a), 48'd0);
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) seen++;
    end
    check("mid_rst_no_result", 48'(seen), 48'd0);
    check("mid_rst_idle", 48'(busy), 48'd0);
    do_cmd(8'd2);
    send_pair(18'sd1, 18'sd1);
    send_pair(18'sd2, 18'sd2);
    wait_result("j7", 48'd5, 5);
    take_result("j7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
